// File: rtl/mem_wb_skid_if.sv
// mem_wb_skid_if: handshake and payload bundle between the MEM stage,
// the MEM/WB skid register and the write-back stage.
//
// Upstream side (MEM -> block): in_valid / in_ready plus the EX_MEM_*
// control and data fields and the raw Read_Data word.
// Downstream side (block -> WB): out_valid / out_ready plus the MEM_WB_*
// registered fields.
//
// Modports:
//   slave  - the view taken by mem_wb_skid itself
//   master - the view taken by the surrounding pipeline (MEM producer and
//            WB consumer)
interface mem_wb_skid_if #(
    parameter int DATA_W = 64,
    parameter int RD_W   = 5
);
    // upstream handshake and payload
    logic              in_valid;
    logic              in_ready;
    logic              EX_MEM_RegWrite;
    logic              EX_MEM_MemtoReg;
    logic [RD_W-1:0]   EX_MEM_rd;
    logic [DATA_W-1:0] EX_MEM_ALU_Out;
    logic [DATA_W-1:0] Read_Data;
    logic [1:0]        EX_MEM_LdSize;
    logic              EX_MEM_LdUnsigned;

    // downstream handshake and payload
    logic              out_ready;
    logic              out_valid;
    logic              MEM_WB_RegWrite;
    logic              MEM_WB_MemtoReg;
    logic [RD_W-1:0]   MEM_WB_rd;
    logic [DATA_W-1:0] MEM_WB_ALU_Out;
    logic [DATA_W-1:0] MEM_WB_Read_Data;

    modport slave (
        input  in_valid,
        input  EX_MEM_RegWrite,
        input  EX_MEM_MemtoReg,
        input  EX_MEM_rd,
        input  EX_MEM_ALU_Out,
        input  Read_Data,
        input  EX_MEM_LdSize,
        input  EX_MEM_LdUnsigned,
        input  out_ready,
        output in_ready,
        output out_valid,
        output MEM_WB_RegWrite,
        output MEM_WB_MemtoReg,
        output MEM_WB_rd,
        output MEM_WB_ALU_Out,
        output MEM_WB_Read_Data
    );

    modport master (
        output in_valid,
        output EX_MEM_RegWrite,
        output EX_MEM_MemtoReg,
        output EX_MEM_rd,
        output EX_MEM_ALU_Out,
        output Read_Data,
        output EX_MEM_LdSize,
        output EX_MEM_LdUnsigned,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  MEM_WB_RegWrite,
        input  MEM_WB_MemtoReg,
        input  MEM_WB_rd,
        input  MEM_WB_ALU_Out,
        input  MEM_WB_Read_Data
    );
endinterface

// File: rtl/mem_wb_skid.sv
// mem_wb_skid: MEM/WB pipeline register with a valid/ready handshake,
// a 2-entry skid buffer (main + skid), synchronous flush, and load-data
// byte selection with sign/zero extension performed at capture time so
// write-back sees a final value.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   reset  - asynchronous active-high reset, drops both entries and zeroes
//            the outputs immediately
//   flush  - synchronous kill of the held entries and of the incoming one
//   bus    - mem_wb_skid_if.slave: in_valid/in_ready + EX_MEM_* fields on
//            the upstream side, out_valid/out_ready + MEM_WB_* on the
//            downstream side
//
// Parameters:
//   DATA_W - datapath width, 32 or 64
//   RD_W   - destination register index width
module mem_wb_skid #(
    parameter int DATA_W = 64,
    parameter int RD_W   = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    mem_wb_skid_if.slave bus
);
    // byte-offset width inside one datapath word
    localparam int OFS_W = $clog2(DATA_W / 8);

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] alu_out;
        logic [DATA_W-1:0] read_data;
    } entry_t;

    // Select the addressed byte/halfword/word out of the raw memory word and
    // extend it to DATA_W. The offset is first aligned to the access size by
    // clearing the low bits (all-ones mask shifted left by log2(size)); for
    // sizes at or above the word width the mask becomes zero, which makes a
    // D access on a 32-bit datapath behave exactly like W.
    function automatic logic [DATA_W-1:0] load_align(
        input logic [DATA_W-1:0] raw,
        input logic [OFS_W-1:0]  ofs,
        input logic [1:0]        size,
        input logic              is_unsigned
    );
        logic [OFS_W-1:0]  ofs_mask;
        logic [OFS_W-1:0]  byte_ofs;
        logic [DATA_W-1:0] shifted;
        logic [DATA_W-1:0] keep;
        logic              sign_bit;

        ofs_mask = {OFS_W{1'b1}} << size;
        byte_ofs = ofs & ofs_mask;
        shifted  = raw >> {byte_ofs, 3'b000};

        case (size)
            2'd0: begin
                keep     = DATA_W'(8'hFF);
                sign_bit = shifted[7];
            end
            2'd1: begin
                keep     = DATA_W'(16'hFFFF);
                sign_bit = shifted[15];
            end
            2'd2: begin
                keep     = DATA_W'(32'hFFFF_FFFF);
                sign_bit = shifted[31];
            end
            default: begin
                keep     = '1;
                sign_bit = 1'b0;
            end
        endcase

        return (shifted & keep) | ((!is_unsigned && sign_bit) ? ~keep : '0);
    endfunction

    entry_t main_p1;
    entry_t skid_p1;
    logic   main_vld_p1;
    logic   skid_vld_p1;

    entry_t incoming_p0;
    logic   accept;
    logic   drain;
    logic   main_free;

    // ---- capture stage: build the entry presented by MEM ----
    always_comb begin
        incoming_p0            = '0;
        incoming_p0.reg_write  = bus.EX_MEM_RegWrite;
        incoming_p0.mem_to_reg = bus.EX_MEM_MemtoReg;
        incoming_p0.rd         = bus.EX_MEM_rd;
        incoming_p0.alu_out    = bus.EX_MEM_ALU_Out;
        if (bus.EX_MEM_MemtoReg) begin
            incoming_p0.read_data = load_align(bus.Read_Data,
                                               bus.EX_MEM_ALU_Out[OFS_W-1:0],
                                               bus.EX_MEM_LdSize,
                                               bus.EX_MEM_LdUnsigned);
        end else begin
            incoming_p0.read_data = bus.Read_Data;
        end
    end

    // in_ready is a pure function of the registered skid valid bit, so it
    // carries no combinational path from out_ready.
    assign accept    = bus.in_valid && bus.in_ready && !flush;
    assign drain     = main_vld_p1 && bus.out_ready;
    assign main_free = !main_vld_p1 || drain;

    // ---- register stage: valid bits (main / skid occupancy) ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_vld_p1 <= 1'b0;
            skid_vld_p1 <= 1'b0;
        end else if (flush) begin
            main_vld_p1 <= 1'b0;
            skid_vld_p1 <= 1'b0;
        end else if (main_free) begin
            if (skid_vld_p1) begin
                // skid refills main; accept is 0 here because in_ready=0
                main_vld_p1 <= 1'b1;
                skid_vld_p1 <= accept;
            end else begin
                main_vld_p1 <= accept;
                skid_vld_p1 <= 1'b0;
            end
        end else if (accept) begin
            skid_vld_p1 <= 1'b1;
        end
    end

    // Main payload is reset so the outputs read zero while reset is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_p1 <= '0;
        end else if (!flush && main_free) begin
            if (skid_vld_p1) begin
                main_p1 <= skid_p1;
            end else if (accept) begin
                main_p1 <= incoming_p0;
            end
        end
    end

    // Skid payload only matters while skid_vld_p1 is set, so it carries no
    // reset. It is written only while main is holding a stalled entry.
    always_ff @(posedge clk) begin
        if (accept && main_vld_p1 && !drain) begin
            skid_p1 <= incoming_p0;
        end
    end

    // ---- output stage ----
    assign bus.in_ready         = !skid_vld_p1;
    assign bus.out_valid        = main_vld_p1;
    assign bus.MEM_WB_RegWrite  = main_p1.reg_write && main_vld_p1 && (main_p1.rd != '0);
    assign bus.MEM_WB_MemtoReg  = main_p1.mem_to_reg;
    assign bus.MEM_WB_rd        = main_p1.rd;
    assign bus.MEM_WB_ALU_Out   = main_p1.alu_out;
    assign bus.MEM_WB_Read_Data = main_p1.read_data;
endmodule

// File: tb/tb_mem_wb_skid.sv
module tb_mem_wb_skid;
    localparam int DATA_W = 64;
    localparam int RD_W   = 5;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    bit   chk_en = 1'b0;

    int npass = 0;
    int ntot  = 0;

    mem_wb_skid_if #(.DATA_W(DATA_W), .RD_W(RD_W)) bus ();

    mem_wb_skid #(.DATA_W(DATA_W), .RD_W(RD_W)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end else begin
            npass++;
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic        rw;
        logic        m2r;
        logic [4:0]  rd;
        logic [63:0] alu;
        logic [63:0] data;
    } ent_t;

    ent_t q[$];

    // Load value: pick n = 2^size bytes at the offset rounded down to a
    // multiple of n, then extend.
    function automatic logic [63:0] m_ext(input logic [63:0] raw, input int ofs,
                                          input int size, input bit uns);
        int          n;
        int          base;
        logic [63:0] v;
        logic [63:0] lowmask;
        n    = 1 << size;
        base = (ofs / n) * n;
        v    = raw >> (8 * base);
        if (n < 8) begin
            lowmask = (64'd1 << (8 * n)) - 64'd1;
            v       = v & lowmask;
            if (!uns && v[8*n-1]) v = v | ~lowmask;
        end
        return v;
    endfunction

    function automatic ent_t mk();
        ent_t e;
        e.rw  = bus.EX_MEM_RegWrite;
        e.m2r = bus.EX_MEM_MemtoReg;
        e.rd  = bus.EX_MEM_rd;
        e.alu = bus.EX_MEM_ALU_Out;
        e.data = bus.EX_MEM_MemtoReg ?
                 m_ext(bus.Read_Data, int'(bus.EX_MEM_ALU_Out[2:0]),
                       int'(bus.EX_MEM_LdSize), bus.EX_MEM_LdUnsigned) :
                 bus.Read_Data;
        return e;
    endfunction

    // FIFO of at most two live entries; ready while fewer than two are held.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
        end else if (flush) begin
            q.delete();
        end else begin
            bit acc;
            acc = bus.in_valid && (q.size() < 2);
            if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
            if (acc) q.push_back(mk());
        end
    end

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            chk("m_in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
            chk("m_out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
            if (q.size() > 0) begin
                chk("m_regwrite", 64'(bus.MEM_WB_RegWrite), 64'(q[0].rw && q[0].rd != 5'd0));
                chk("m_memtoreg", 64'(bus.MEM_WB_MemtoReg), 64'(q[0].m2r));
                chk("m_rd", 64'(bus.MEM_WB_rd), 64'(q[0].rd));
                chk("m_alu", bus.MEM_WB_ALU_Out, q[0].alu);
                chk("m_rdata", bus.MEM_WB_Read_Data, q[0].data);
            end else begin
                chk("m_regwrite_idle", 64'(bus.MEM_WB_RegWrite), 64'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        bus.in_valid          = 1'b0;
        bus.EX_MEM_RegWrite   = 1'b0;
        bus.EX_MEM_MemtoReg   = 1'b0;
        bus.EX_MEM_rd         = '0;
        bus.EX_MEM_ALU_Out    = '0;
        bus.Read_Data         = '0;
        bus.EX_MEM_LdSize     = 2'd0;
        bus.EX_MEM_LdUnsigned = 1'b0;
    endtask

    task automatic drive(input logic rw, input logic m2r, input logic [4:0] rd,
                         input logic [63:0] alu, input logic [63:0] rdat,
                         input logic [1:0] sz, input logic uns);
        bus.in_valid          = 1'b1;
        bus.EX_MEM_RegWrite   = rw;
        bus.EX_MEM_MemtoReg   = m2r;
        bus.EX_MEM_rd         = rd;
        bus.EX_MEM_ALU_Out    = alu;
        bus.Read_Data         = rdat;
        bus.EX_MEM_LdSize     = sz;
        bus.EX_MEM_LdUnsigned = uns;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        chk({tag, "_regwrite"}, 64'(bus.MEM_WB_RegWrite), 64'd0);
        chk({tag, "_memtoreg"}, 64'(bus.MEM_WB_MemtoReg), 64'd0);
        chk({tag, "_rd"}, 64'(bus.MEM_WB_rd), 64'd0);
        chk({tag, "_alu"}, bus.MEM_WB_ALU_Out, 64'd0);
        chk({tag, "_rdata"}, bus.MEM_WB_Read_Data, 64'd0);
    endtask

    localparam logic [63:0] LD_WORD = 64'h8877_6655_4433_22F1;
    int          ld_ofs [8] = '{0, 0, 6, 4, 0, 7, 4, 3};
    int          ld_sz  [8] = '{0, 0, 1, 2, 3, 1, 2, 0};
    int          ld_uns [8] = '{0, 1, 0, 1, 0, 0, 0, 1};
    logic [63:0] ld_exp [8] = '{64'hFFFF_FFFF_FFFF_FFF1,
                                64'h0000_0000_0000_00F1,
                                64'hFFFF_FFFF_FFFF_8877,
                                64'h0000_0000_8877_6655,
                                64'h8877_6655_4433_22F1,
                                64'hFFFF_FFFF_FFFF_8877,
                                64'hFFFF_FFFF_8877_6655,
                                64'h0000_0000_0000_0044};

    initial begin
        idle();
        bus.out_ready = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk_all_zero("reset0");
        @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;

        // streaming, out_ready held high
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i < 4) drive(1'b1, 1'b0, 5'(i + 1), 64'(16 + i), 64'(32'hDEAD_0000 + i), 2'd3, 1'b0);
            else idle();
            @(negedge clk);
            if (i >= 1 && i <= 4) begin
                chk("stream_valid", 64'(bus.out_valid), 64'd1);
                chk("stream_rd", 64'(bus.MEM_WB_rd), 64'(i));
                chk("stream_alu", bus.MEM_WB_ALU_Out, 64'(16 + i - 1));
            end else if (i == 5) begin
                chk("stream_tail_valid", 64'(bus.out_valid), 64'd0);
            end
        end

        // back-pressure: A held, B in skid, C refused until space frees
        bus.out_ready = 1'b0;
        @(posedge clk); #1 drive(1'b1, 1'b0, 5'd5, 64'hA0, 64'h1, 2'd3, 1'b0);
        @(posedge clk); #1 drive(1'b1, 1'b0, 5'd6, 64'hB0, 64'h2, 2'd3, 1'b0);
        @(posedge clk); #1 drive(1'b1, 1'b0, 5'd7, 64'hC0, 64'h3, 2'd3, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_hold_rd", 64'(bus.MEM_WB_rd), 64'd5);
        chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_second_rd", 64'(bus.MEM_WB_rd), 64'd6);
        @(posedge clk); #1 idle();
        @(negedge clk);
        chk("bp_third_rd", 64'(bus.MEM_WB_rd), 64'd7);
        @(negedge clk);
        chk("bp_empty", 64'(bus.out_valid), 64'd0);

        // load extraction
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            if (i < 8) drive(1'b1, 1'b1, 5'(10 + i), 64'h2000 + 64'(ld_ofs[i]), LD_WORD,
                             2'(ld_sz[i]), ld_uns[i] != 0);
            else idle();
            @(negedge clk);
            if (i >= 1) begin
                chk("load_rdata", bus.MEM_WB_Read_Data, ld_exp[i-1]);
                chk("load_rd", 64'(bus.MEM_WB_rd), 64'(10 + i - 1));
            end
        end

        // rd = 0 gates the write enable but not the payload
        @(posedge clk); #1 drive(1'b1, 1'b0, 5'd0, 64'h55, 64'h66, 2'd3, 1'b0);
        @(posedge clk); #1 idle();
        @(negedge clk);
        chk("rd0_valid", 64'(bus.out_valid), 64'd1);
        chk("rd0_regwrite", 64'(bus.MEM_WB_RegWrite), 64'd0);
        chk("rd0_alu", bus.MEM_WB_ALU_Out, 64'h55);
        chk("rd0_rdata", bus.MEM_WB_Read_Data, 64'h66);
        @(negedge clk);

        // flush with both entries full and a new input pending
        bus.out_ready = 1'b0;
        @(posedge clk); #1 drive(1'b1, 1'b0, 5'd1, 64'h77, 64'h0, 2'd3, 1'b0);
        @(posedge clk); #1 drive(1'b1, 1'b0, 5'd2, 64'h78, 64'h0, 2'd3, 1'b0);
        @(posedge clk); #1 drive(1'b1, 1'b0, 5'd3, 64'h79, 64'h0, 2'd3, 1'b0);
        flush = 1'b1;
        @(posedge clk); #1 idle();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("flush_never_presented", 64'(bus.out_valid), 64'd0);

        // asynchronous reset mid-cycle with the skid full
        bus.out_ready = 1'b0;
        @(posedge clk); #1 drive(1'b1, 1'b1, 5'd8, 64'h3000, LD_WORD, 2'd0, 1'b0);
        @(posedge clk); #1 drive(1'b1, 1'b0, 5'd9, 64'h3001, 64'h9, 2'd3, 1'b0);
        @(posedge clk); #1 idle();
        @(negedge clk);
        chk("prereset_full", 64'(bus.in_ready), 64'd0);
        #2 reset = 1'b1;
        #1;
        chk_all_zero("reset_mid");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_valid", 64'(bus.out_valid), 64'd0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
